// File: rtl/im_loader.sv
// im_loader: boot-time loader that turns a UART byte stream into
// instruction-memory writes. The stream is a big-endian 32-bit word
// count N followed by N big-endian words. Words land at consecutive
// word-aligned addresses from BASE_ADDR. The CPU is held in reset until
// a load completes successfully.
module im_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h00003000,
  parameter int          MAX_WORDS = 4096
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  byte_in,
  input  logic        byte_valid,
  input  logic        restart,
  output logic        ready,
  output logic        we,
  output logic [31:0] waddr,
  output logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic        cpu_hold
);

  // Word index and latched count are wide enough to hold MAX_WORDS
  // itself: the index reaches N after the last write, and N may equal
  // MAX_WORDS.
  localparam int IDX_W = $clog2(MAX_WORDS) + 1;

  localparam logic [1:0] ST_HDR  = 2'd0;
  localparam logic [1:0] ST_DATA = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;
  localparam logic [1:0] ST_ERR  = 2'd3;

  logic [1:0]       state_q,    state_d;
  logic [1:0]       byte_cnt_q, byte_cnt_d;
  logic [31:0]      shift_q,    shift_d;
  logic [IDX_W-1:0] index_q,    index_d;
  logic [IDX_W-1:0] count_q,    count_d;
  logic             ready_q,    ready_d;
  logic             we_q,       we_d;
  logic [31:0]      waddr_q,    waddr_d;
  logic [31:0]      wdata_q,    wdata_d;
  logic             busy_q,     busy_d;
  logic             done_q,     done_d;
  logic             err_q,      err_d;
  logic             cpu_hold_q, cpu_hold_d;

  // Helper terms shared by the header and data paths.
  logic             accept;
  logic             last_byte;
  logic [31:0]      full_word;
  logic [IDX_W-1:0] index_inc;

  assign accept    = byte_valid && ready_q;
  assign last_byte = (byte_cnt_q == 2'd3);
  // The word completed by the byte arriving this cycle; the shift
  // register itself only catches up at the next edge.
  assign full_word = {shift_q[23:0], byte_in};
  assign index_inc = index_q + IDX_W'(1);

  // Next-state logic for the loader FSM and all registered outputs.
  always_comb begin
    // NOTE: every *_d gets a default before any branch so that no path
    // leaves a signal unassigned, which would infer a latch.
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    shift_d    = shift_q;
    index_d    = index_q;
    count_d    = count_q;
    ready_d    = ready_q;
    we_d       = 1'b0;
    waddr_d    = waddr_q;
    wdata_d    = wdata_q;
    busy_d     = busy_q;
    done_d     = done_q;
    err_d      = err_q;
    cpu_hold_d = cpu_hold_q;

    case (state_q)
      ST_HDR: begin
        if (accept) begin
          shift_d    = full_word;
          byte_cnt_d = byte_cnt_q + 2'd1;
          busy_d     = 1'b1;
          if (last_byte) begin
            if (full_word > 32'(MAX_WORDS)) begin
              state_d = ST_ERR;
              err_d   = 1'b1;
              busy_d  = 1'b0;
              ready_d = 1'b0;
            end else if (full_word == 32'd0) begin
              state_d    = ST_DONE;
              done_d     = 1'b1;
              busy_d     = 1'b0;
              cpu_hold_d = 1'b0;
              ready_d    = 1'b0;
            end else begin
              state_d = ST_DATA;
              index_d = '0;
              count_d = full_word[IDX_W-1:0];
            end
          end
        end
      end

      ST_DATA: begin
        if (accept) begin
          shift_d    = full_word;
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (last_byte) begin
            we_d    = 1'b1;
            wdata_d = full_word;
            waddr_d = BASE_ADDR + 32'({index_q, 2'b00});
            index_d = index_inc;
            // The final write and done leave the registers together.
            if (index_inc == count_q) begin
              state_d    = ST_DONE;
              done_d     = 1'b1;
              busy_d     = 1'b0;
              cpu_hold_d = 1'b0;
              ready_d    = 1'b0;
            end
          end
        end
      end

      // DONE and ERR ignore bytes; only restart leaves them.
      default: begin
        if (restart) begin
          state_d    = ST_HDR;
          done_d     = 1'b0;
          err_d      = 1'b0;
          busy_d     = 1'b0;
          index_d    = '0;
          byte_cnt_d = 2'd0;
          cpu_hold_d = 1'b1;
          ready_d    = 1'b1;
        end
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (reset) begin
      state_q    <= ST_HDR;
      byte_cnt_q <= 2'd0;
      shift_q    <= '0;
      index_q    <= '0;
      count_q    <= '0;
      ready_q    <= 1'b1;
      we_q       <= 1'b0;
      waddr_q    <= BASE_ADDR;
      wdata_q    <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      cpu_hold_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      shift_q    <= shift_d;
      index_q    <= index_d;
      count_q    <= count_d;
      ready_q    <= ready_d;
      we_q       <= we_d;
      waddr_q    <= waddr_d;
      wdata_q    <= wdata_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
      cpu_hold_q <= cpu_hold_d;
    end
  end

  assign ready    = ready_q;
  assign we       = we_q;
  assign waddr    = waddr_q;
  assign wdata    = wdata_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign err      = err_q;
  assign cpu_hold = cpu_hold_q;

endmodule

// File: tb/tb_im_loader.sv
// tb_im_loader: directed plus randomized scenarios for im_loader. The
// expected write list is derived from the image contents alone: word i
// of the image must appear at BASE + 4*i, in order, once.
module tb_im_loader;

  localparam logic [31:0] BASE      = 32'h00003000;
  localparam int          MAX_WORDS = 4096;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  byte_in;
  logic        byte_valid;
  logic        restart;
  logic        ready;
  logic        we;
  logic [31:0] waddr;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic        err;
  logic        cpu_hold;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic        done;
    logic        hold;
  } wr_t;

  wr_t         wr_q[$];   // writes observed on the IM port
  logic [31:0] img_q[$];  // image words for the current load

  im_loader #(.BASE_ADDR(BASE), .MAX_WORDS(MAX_WORDS)) dut (
    .clk       (clk),
    .reset     (reset),
    .byte_in   (byte_in),
    .byte_valid(byte_valid),
    .restart   (restart),
    .ready     (ready),
    .we        (we),
    .waddr     (waddr),
    .wdata     (wdata),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .cpu_hold  (cpu_hold)
  );

  always #5 clk = ~clk;

  // Record every write strobe, half a cycle after the edge that set it.
  always @(negedge clk) begin
    if (we === 1'b1) wr_q.push_back('{addr: waddr, data: wdata, done: done, hold: cpu_hold});
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Present one byte for exactly one cycle; returns half a cycle after
  // the edge that consumed it.
  task automatic send_byte(input logic [7:0] b, input int max_gap);
    idle((max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0);
    byte_valid = 1'b1;
    byte_in    = b;
    @(negedge clk);
    byte_valid = 1'b0;
    byte_in    = 8'h00;
  endtask

  task automatic send_word(input logic [31:0] w, input int max_gap);
    for (int s = 3; s >= 0; s--) send_byte(8'((w >> (8 * s)) & 32'hFF), max_gap);
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic pulse_restart(input string tag);
    restart = 1'b1;
    @(negedge clk);
    restart = 1'b0;
    check({tag, "_rst_done"}, 32'(done), 32'd0);
    check({tag, "_rst_err"},  32'(err), 32'd0);
    check({tag, "_rst_hold"}, 32'(cpu_hold), 32'd1);
    check({tag, "_rst_ready"}, 32'(ready), 32'd1);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_ready"}, 32'(ready), 32'd1);
    check({tag, "_we"},    32'(we), 32'd0);
    check({tag, "_wdata"}, wdata, 32'd0);
    check({tag, "_waddr"}, waddr, BASE);
    check({tag, "_busy"},  32'(busy), 32'd0);
    check({tag, "_done"},  32'(done), 32'd0);
    check({tag, "_err"},   32'(err), 32'd0);
    check({tag, "_hold"},  32'(cpu_hold), 32'd1);
  endtask

  // Compare observed writes against the image: word i at BASE + 4*i.
  task automatic check_writes(input string tag);
    check({tag, "_wr_count"}, 32'(wr_q.size()), 32'(img_q.size()));
    for (int i = 0; i < img_q.size() && i < wr_q.size(); i++) begin
      check({tag, "_waddr"}, wr_q[i].addr, BASE + 32'(4 * i));
      check({tag, "_wdata"}, wr_q[i].data, img_q[i]);
    end
    if (wr_q.size() > 0) begin
      check({tag, "_last_done"}, 32'(wr_q[wr_q.size()-1].done), 32'd1);
      check({tag, "_last_hold"}, 32'(wr_q[wr_q.size()-1].hold), 32'd0);
    end
  endtask

  // Send header n_hdr then img_q, and check the outcome the stream's
  // rules predict: error, empty image, or one write per word.
  task automatic run_load(input string tag, input logic [31:0] n_hdr, input int max_gap);
    wr_q.delete();
    check({tag, "_busy_pre"}, 32'(busy), 32'd0);
    send_byte(n_hdr[31:24], max_gap);
    check({tag, "_busy_hdr"}, 32'(busy), 32'd1);
    send_byte(n_hdr[23:16], max_gap);
    send_byte(n_hdr[15:8], max_gap);
    send_byte(n_hdr[7:0], max_gap);
    if (n_hdr > 32'(MAX_WORDS)) begin
      check({tag, "_err"},   32'(err), 32'd1);
      check({tag, "_ready"}, 32'(ready), 32'd0);
      check({tag, "_hold"},  32'(cpu_hold), 32'd1);
      check({tag, "_busy"},  32'(busy), 32'd0);
      check({tag, "_done"},  32'(done), 32'd0);
      send_word(32'h11223344, max_gap);
      send_word(32'h55667788, max_gap);
      idle(2);
      check({tag, "_err_hold"}, 32'(err), 32'd1);
      check({tag, "_no_we"}, 32'(wr_q.size()), 32'd0);
    end else if (n_hdr == 32'd0) begin
      check({tag, "_done"},  32'(done), 32'd1);
      check({tag, "_we"},    32'(we), 32'd0);
      check({tag, "_hold"},  32'(cpu_hold), 32'd0);
      check({tag, "_ready"}, 32'(ready), 32'd0);
      idle(2);
      check({tag, "_no_we"}, 32'(wr_q.size()), 32'd0);
    end else begin
      for (int i = 0; i < img_q.size(); i++) begin
        send_word(img_q[i], max_gap);
        if (i + 1 < img_q.size()) begin
          check({tag, "_busy_mid"}, 32'(busy), 32'd1);
          check({tag, "_done_mid"}, 32'(done), 32'd0);
        end
      end
      check({tag, "_we_last"},   32'(we), 32'd1);
      check({tag, "_done"},      32'(done), 32'd1);
      check({tag, "_hold"},      32'(cpu_hold), 32'd0);
      check({tag, "_ready"},     32'(ready), 32'd0);
      check({tag, "_busy_end"},  32'(busy), 32'd0);
      idle(1);
      check({tag, "_we_drop"},   32'(we), 32'd0);
      check({tag, "_wdata_hold"}, wdata, img_q[img_q.size()-1]);
      check_writes(tag);
    end
  endtask

  initial begin
    reset      = 1'b1;
    byte_valid = 1'b0;
    byte_in    = 8'h00;
    restart    = 1'b0;
    idle(2);
    reset = 1'b0;
    check_reset_state("reset");

    // Nominal two-word load, bytes every cycle.
    img_q = '{32'h24080005, 32'h3C011234};
    run_load("nominal", 32'd2, 0);

    // Bytes arriving in DONE are dropped.
    wr_q.delete();
    send_word(32'hA5A5A5A5, 0);
    idle(1);
    check("done_drop_we", 32'(wr_q.size()), 32'd0);
    check("done_drop_done", 32'(done), 32'd1);

    // Restart and load a single word.
    pulse_restart("restart1");
    img_q = '{32'h00000001};
    run_load("restart_load", 32'd1, 0);

    // Same nominal stream with random idle gaps.
    pulse_restart("restart2");
    img_q = '{32'h24080005, 32'h3C011234};
    run_load("gapped", 32'd2, 5);

    // Random images with random gaps.
    for (int r = 0; r < 6; r++) begin
      int n;
      pulse_restart("restart_rand");
      n = int'($urandom_range(7, 1));
      img_q.delete();
      for (int i = 0; i < n; i++) img_q.push_back($urandom);
      run_load("random", 32'(n), (r % 2 == 0) ? 0 : 5);
    end

    // Empty image.
    pulse_restart("restart3");
    img_q.delete();
    run_load("empty", 32'd0, 0);

    // Oversize header, then restart out of ERR.
    pulse_restart("restart4");
    run_load("oversize", 32'd4097, 0);
    pulse_restart("restart5");
    run_load("oversize_big", 32'h80000000, 3);

    // Reset mid-word abandons the partial word; reset beats a byte.
    pulse_restart("restart6");
    wr_q.delete();
    send_word(32'd1, 0);
    send_byte(8'h12, 0);
    send_byte(8'h34, 0);
    reset      = 1'b1;
    byte_valid = 1'b1;
    byte_in    = 8'h77;
    restart    = 1'b1;
    @(negedge clk);
    reset      = 1'b0;
    byte_valid = 1'b0;
    restart    = 1'b0;
    check_reset_state("midword_reset");
    check("midword_no_we", 32'(wr_q.size()), 32'd0);
    img_q = '{32'hDEADBEEF};
    run_load("midword_reload", 32'd1, 0);

    // Reset mid-header: the next byte starts a fresh header.
    pulse_reset();
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    pulse_reset();
    check_reset_state("midhdr_reset");
    img_q = '{32'hCAFEF00D, 32'h0BADC0DE};
    run_load("midhdr_reload", 32'd2, 2);

    // Largest legal image: MAX_WORDS words, back-to-back.
    pulse_restart("restart7");
    img_q.delete();
    for (int i = 0; i < MAX_WORDS; i++) img_q.push_back($urandom);
    run_load("max_words", 32'(MAX_WORDS), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
